// File: rtl/nibble_rx.sv
// Serial nibble receiver: input synchroniser, start/data/stop framing FSM,
// registered valid/frame_err strobes and a wrapping good-frame counter.
module nibble_rx #(
  parameter int CLKS_PER_BIT = 5000,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic       rx,
  output logic [3:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy,
  output logic [7:0] frame_count
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t                 state, state_nx;
  logic [SYNC_STAGES-1:0] sync;
  logic                   rxs;
  logic [CW-1:0]          cnt, cnt_nx;
  logic [1:0]             idx, idx_nx;
  logic [3:0]             shreg, shreg_nx, data_nx;
  logic                   valid_nx, ferr_nx;
  logic [7:0]             fcnt_nx;
  logic                   expire;

  // Stages reset high so leaving reset never looks like a start bit.
  always_ff @(posedge sysclk or posedge rst)
    if (rst) sync <= '1;
    else     sync <= {sync[SYNC_STAGES-2:0], rx};

  assign rxs    = sync[SYNC_STAGES-1];
  assign expire = (cnt == ONE);
  assign busy   = (state != IDLE);

  always_ff @(posedge sysclk or posedge rst)
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      shreg       <= '0;
      data        <= '0;
      valid       <= 1'b0;
      frame_err   <= 1'b0;
      frame_count <= '0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      idx         <= idx_nx;
      shreg       <= shreg_nx;
      data        <= data_nx;
      valid       <= valid_nx;
      frame_err   <= ferr_nx;
      frame_count <= fcnt_nx;
    end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    shreg_nx = shreg;
    data_nx  = data;
    valid_nx = 1'b0;
    ferr_nx  = 1'b0;
    fcnt_nx  = frame_count;
    case (state)
      IDLE:
        if (!rxs) begin
          state_nx = START;
          cnt_nx   = HALF;
        end
      START:
        if (expire) begin
          // A start bit that is gone by mid-bit is a glitch: drop silently.
          if (!rxs) begin
            state_nx = DATA;
            idx_nx   = 2'd0;
            cnt_nx   = FULL;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          cnt_nx = cnt - ONE;
        end
      DATA:
        if (expire) begin
          shreg_nx[idx] = rxs;
          cnt_nx        = FULL;
          if (idx == 2'd3) state_nx = STOP;
          else             idx_nx   = idx + 2'd1;
        end else begin
          cnt_nx = cnt - ONE;
        end
      STOP:
        if (expire) begin
          if (rxs) begin
            data_nx  = shreg;
            valid_nx = 1'b1;
            fcnt_nx  = frame_count + 8'd1;
            state_nx = IDLE;
          end else begin
            ferr_nx  = 1'b1;
            state_nx = WAIT_IDLE;
          end
        end else begin
          cnt_nx = cnt - ONE;
        end
      WAIT_IDLE:
        if (rxs) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
endmodule
